// File: rtl/sub_8bit_pipe_pkg.sv
// Shared types and widths for the two-stage 8-bit subtractor pipeline.
package sub_pkg;

    localparam int NIBBLE_W = 4;
    localparam int WORD_W   = 2 * NIBBLE_W;

    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [WORD_W-1:0]   word_t;

endpackage

// File: rtl/sub_8bit_pipe_if.sv
// Operand/result handshake bundle; the producer/consumer side takes the master modport.
interface sub_8bit_pipe_if;
    import sub_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t a;
    word_t b;
    logic  b_in;
    logic  out_valid;
    logic  out_ready;
    word_t diff;
    logic  b_out;

    modport master (
        output in_valid, a, b, b_in, out_ready,
        input  in_ready, out_valid, diff, b_out
    );

    modport slave (
        input  in_valid, a, b, b_in, out_ready,
        output in_ready, out_valid, diff, b_out
    );

endinterface

// File: rtl/sub_8bit_pipe_nibble_la.sv
// 4-bit generate/propagate lookahead computing a + ~b + c_in (subtraction with carry = !borrow).
module sub_nibble_la
    import sub_pkg::*;
(
    input  nibble_t a,
    input  nibble_t b,
    input  logic    c_in,
    output nibble_t d,
    output logic    c_out
);

    nibble_t             g_s;
    nibble_t             p_s;
    logic [NIBBLE_W:0]   c_s;

    // Flattened lookahead carries so no carry ripples through the nibble.
    always_comb begin
        g_s    = a & ~b;
        p_s    = a ^ ~b;
        c_s[0] = c_in;
        c_s[1] = g_s[0] | (p_s[0] & c_in);
        c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & c_in);
        c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
               | (p_s[2] & p_s[1] & p_s[0] & c_in);
        c_s[4] = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
               | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
               | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & c_in);
        d      = p_s ^ c_s[NIBBLE_W-1:0];
        c_out  = c_s[NIBBLE_W];
    end

endmodule

// File: rtl/sub_8bit_pipe.sv
// Two-stage valid/ready 8-bit subtractor: low nibble in stage 1, high nibble and borrow in stage 2.
// Optional build macro SUB_SAT_EN clamps diff to 0x00 whenever a borrow-out occurs.
module sub_8bit_pipe
    import sub_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    sub_8bit_pipe_if.slave bus
);

    logic    s1_valid_r;
    nibble_t s1_d_lo_r;
    logic    s1_c_r;
    nibble_t s1_a_hi_r;
    nibble_t s1_b_hi_r;
    logic    s2_valid_r;
    word_t   diff_r;
    logic    b_out_r;

    logic    s1_adv_s;
    logic    s2_adv_s;
    nibble_t lo_d_s;
    logic    lo_c_s;
    nibble_t hi_d_s;
    logic    hi_c_s;
    word_t   res_diff_s;

    sub_nibble_la u_lo (
        .a     (bus.a[NIBBLE_W-1:0]),
        .b     (bus.b[NIBBLE_W-1:0]),
        .c_in  (~bus.b_in),
        .d     (lo_d_s),
        .c_out (lo_c_s)
    );

    sub_nibble_la u_hi (
        .a     (s1_a_hi_r),
        .b     (s1_b_hi_r),
        .c_in  (s1_c_r),
        .d     (hi_d_s),
        .c_out (hi_c_s)
    );

    // Stage advance: an empty stage always accepts, so bubbles collapse.
    always_comb begin
        s2_adv_s = !s2_valid_r || bus.out_ready;
        s1_adv_s = !s1_valid_r || s2_adv_s;
`ifdef SUB_SAT_EN
        if (!hi_c_s) begin
            res_diff_s = 8'h00;
        end else begin
            res_diff_s = {hi_d_s, s1_d_lo_r};
        end
`else
        res_diff_s = {hi_d_s, s1_d_lo_r};
`endif
    end

    assign bus.in_ready  = s1_adv_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.diff      = diff_r;
    assign bus.b_out     = b_out_r;

    // Stage 1 register: low-nibble result, nibble carry and the high operand nibbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_d_lo_r  <= 4'h0;
            s1_c_r     <= 1'b0;
            s1_a_hi_r  <= 4'h0;
            s1_b_hi_r  <= 4'h0;
        end else if (s1_adv_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_d_lo_r <= lo_d_s;
                s1_c_r    <= lo_c_s;
                s1_a_hi_r <= bus.a[WORD_W-1:NIBBLE_W];
                s1_b_hi_r <= bus.b[WORD_W-1:NIBBLE_W];
            end
        end
    end

    // Stage 2 register: holds the result steady while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            diff_r     <= 8'h00;
            b_out_r    <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                diff_r  <= res_diff_s;
                b_out_r <= ~hi_c_s;
            end
        end
    end

endmodule

// File: tb/tb_sub_8bit_pipe.sv
// Scoreboard bench for sub_8bit_pipe: the driver queues hand-computed results on accept, a forked monitor pops on output transfers.
module tb_sub_8bit_pipe;

    typedef struct {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   rnd_rdy = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    sub_8bit_pipe_if bus ();

    sub_8bit_pipe dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %03h expected %03h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Independent arithmetic reference for the random run.
    function automatic exp_t ref_sub(input logic [7:0] a, input logic [7:0] b, input logic bi);
        exp_t       r;
        logic [8:0] t;
        t    = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        r.d  = t[7:0];
        r.bo = t[8];
        return r;
    endfunction

    // Drive one operand set (caller is just after a rising edge) and queue its result on accept.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb);
        bit   done;
        exp_t e;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.b_in = bi;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_ready) begin
                e.d  = ed;
                e.bo = eb;
`ifdef SUB_SAT_EN
                if (eb) e.d = 8'h00;
`endif
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        bus.b_in = 1'b0;
    endtask

    task automatic drain(input string name);
        bit done;
        done = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (q.size() == 0) done = 1'b1;
        end
        if (!done) fail_now(name);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        bit         held_v;
        logic [8:0] held;
        exp_t       e;
        held_v = 1'b0;
        held = 9'h000;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v && bus.out_valid) chk("stall_stable", {bus.b_out, bus.diff}, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (q.size() == 0) begin
                        fail_now("unexpected_output");
                    end else begin
                        e = q.pop_front();
                        chk("result", {bus.b_out, bus.diff}, {e.bo, e.d});
                    end
                    held_v = 1'b0;
                end else if (bus.out_valid) begin
                    held_v = 1'b1;
                    held = {bus.b_out, bus.diff};
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t r;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;

        idle();
        bus.out_ready = 1'b0;
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk("reset_out_valid", {8'h00, bus.out_valid}, 9'h000);
        chk("reset_result", {bus.b_out, bus.diff}, 9'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", {8'h00, bus.in_ready}, 9'h001);
        @(posedge clk);
        #1;

        // Latency: accepted at edge N, visible after edge N+1.
        send(8'h50, 8'h20, 1'b0, 8'h30, 1'b0);
        idle();
        @(negedge clk);
        chk("latency_n", {8'h00, bus.out_valid}, 9'h000);
        @(negedge clk);
        chk("latency_n1", {8'h00, bus.out_valid}, 9'h001);
        @(posedge clk);
        #1;

        // Back-to-back directed vectors at full throughput.
        send(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);
        send(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1);
        send(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        send(8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0);
        send(8'h80, 8'h81, 1'b0, 8'hFF, 1'b1);
        send(8'hF0, 8'h0F, 1'b1, 8'hE0, 1'b0);
        send(8'h3C, 8'h3C, 1'b1, 8'hFF, 1'b1);
        send(8'h3C, 8'h3B, 1'b1, 8'h00, 1'b0);
        idle();
        drain("drain_directed");

        // Backpressure: two accepts fill the pipe, the third waits.
        bus.out_ready = 1'b0;
        send(8'h05, 8'h01, 1'b0, 8'h04, 1'b0);
        send(8'h09, 8'h02, 1'b0, 8'h07, 1'b0);
        bus.in_valid = 1'b1;
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        bus.b_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {8'h00, bus.in_ready}, 9'h000);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0);
        idle();
        drain("drain_stall");

        // Random streaming run against the arithmetic reference with random backpressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            r   = ref_sub(ra, rb, rbi);
            send(ra, rb, rbi, r.d, r.bo);
        end
        rnd_rdy = 1'b0;
        idle();
        drain("drain_random");

        // Reset with both stages full discards everything.
        bus.out_ready = 1'b0;
        send(8'h44, 8'h11, 1'b0, 8'h33, 1'b0);
        send(8'h22, 8'h11, 1'b0, 8'h11, 1'b0);
        idle();
        @(negedge clk);
        chk("full_before_reset", {8'h00, bus.out_valid}, 9'h001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_valid", {8'h00, bus.out_valid}, 9'h000);
        chk("reset_async_result", {bus.b_out, bus.diff}, 9'h000);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_output", {8'h00, bus.out_valid}, 9'h000);
        end
        chk("ready_after_reset", {8'h00, bus.in_ready}, 9'h001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sub_8bit_pipe.md
SUB_8BIT_PIPE -- requirements
Module: sub_8bit_pipe

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits, split into two 4-bit nibbles.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  a, b and b_in are presented.
REQ-006 in_ready  output  1  block accepts the operands this cycle.
REQ-007 a  input  8  unsigned minuend.
REQ-008 b  input  8  unsigned subtrahend.
REQ-009 b_in  input  1  borrow-in.
REQ-010 out_valid  output  1  diff and b_out hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 diff  output  8  difference.
REQ-013 b_out  output  1  borrow-out.

Function
REQ-014 diff SHALL equal (a - b - b_in) mod 256, computed as a + ~b + carry_in with carry_in = !b_in.
REQ-015 b_out SHALL be 1 exactly when a < b + b_in (unsigned), i.e. b_out = !carry_out.
REQ-016 The pipeline SHALL have two register stages: stage 1 computes the low nibble with 4-bit lookahead and registers diff[3:0], the nibble carry, a[7:4] and b[7:4]; stage 2 computes the high nibble from the registered carry and registers diff and b_out.
REQ-017 Latency SHALL be 2 cycles: operands accepted at edge N appear with out_valid=1 after edge N+1 when there is no backpressure.
REQ-018 Throughput SHALL be one result per cycle while out_ready=1.
REQ-019 A transfer SHALL occur on any edge where valid=1 and ready=1, on either port.
REQ-020 Stage 2 SHALL advance when it is empty (s2_valid=0) or out_ready=1; stage 1 SHALL advance when it is empty or stage 2 advances.
REQ-021 in_ready SHALL equal (!s1_valid || stage-1 advance), combinationally, with no dependency on in_valid.
REQ-022 While out_valid=1 and out_ready=0, diff and b_out SHALL remain stable.
REQ-023 With both stages full and out_ready=0, in_ready SHALL be 0, and no data SHALL be lost or reordered.
REQ-024 On a simultaneous output pop and input push with both stages full, all stages SHALL shift in the same cycle.
REQ-025 Bubbles SHALL collapse: a full stage 1 SHALL move into an empty stage 2 regardless of out_ready.

Reset
REQ-026 When rst_n=0, s1_valid, out_valid, diff, b_out and all stage-1 data SHALL go to 0 asynchronously; in_ready SHALL be 1 after release.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight results, with no result output after release.

Configuration
REQ-028 When SUB_SAT_EN is defined, any result with b_out=1 SHALL present diff=0x00 while b_out stays 1.
REQ-029 Without SUB_SAT_EN, diff SHALL wrap modulo 256; latency and ports SHALL be identical in both builds.

Structure
REQ-030 The shared package sub_pkg SHALL hold NIBBLE_W=4 and the typedef nibble_t.
REQ-031 The 4-bit generate/propagate lookahead SHALL be one combinational sub-module, sub_nibble_la (a, b, c_in -> d, c_out), instanced once per stage.

Verification
REQ-032 a=0x50, b=0x20, b_in=0, out_ready=1 -> after 2 cycles diff=0x30, b_out=0.
REQ-033 a=0x10, b=0x01, b_in=0 -> diff=0x0F, b_out=0 (borrow across nibble); a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1 (with SUB_SAT_EN, diff=0x00, b_out=1).
REQ-034 a=0x00, b=0x01 -> diff=0xFF, b_out=1 (with SUB_SAT_EN, diff=0x00, b_out=1).
REQ-035 Three back-to-back inputs (0x05-0x01, 0x09-0x02, 0xFF-0xFF) with out_ready=0 for 4 cycles -> in_ready drops after two accepts, outputs stay stable, then 0x04, 0x07, 0x00 are delivered in order.
REQ-036 A streaming 256-vector random run with random out_ready -> every result matches the reference model, and there is no loss or duplication.
REQ-037 rst_n pulsed low with both stages full -> out_valid=0 immediately, and no stale output after release.
